// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - issue/writeback sequencer around a 16-bit combinational ALU
//
// Purpose: accepts one instruction at a time over a valid/ready handshake, drives
// registered operands/opcode to an external combinational ALU, and writes the ALU
// result (or a latched immediate for opc 111) back to a small register file.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid, in_ready  instruction handshake
//   instr               {opc[2:0], rd, ra, rb, inc}, MSB first
//   ld_data             immediate for opc 111, sampled with instr
//   alu_a/b/opc/inc     registered ALU inputs
//   alu_w/zer/neg       ALU result and flags
//   done                one-cycle retire pulse
//   res/flag_z/flag_n   value and flags of the last retired instruction
//   dbg_addr/dbg_data   combinational register-file read port
//   icount              retired-instruction counter (only with ALU_ISSUE_SEQ_ICOUNT_EN)
//
// Optional feature macro: ALU_ISSUE_SEQ_ICOUNT_EN
module alu_issue_seq #(
    parameter int DW     = 16,
    parameter int REG_AW = 2
) (
`ifdef ALU_ISSUE_SEQ_ICOUNT_EN
    output logic [15:0]             icount,
`endif
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3+3*REG_AW:0]     instr,
    input  logic [DW-1:0]           ld_data,
    output logic [DW-1:0]           alu_a,
    output logic [DW-1:0]           alu_b,
    output logic [2:0]              alu_opc,
    output logic                    alu_inc,
    input  logic [DW-1:0]           alu_w,
    input  logic                    alu_zer,
    input  logic                    alu_neg,
    output logic                    done,
    output logic [DW-1:0]           res,
    output logic                    flag_z,
    output logic                    flag_n,
    input  logic [REG_AW-1:0]       dbg_addr,
    output logic [DW-1:0]           dbg_data
);

    localparam int IW   = 3 + 3*REG_AW + 1;
    localparam int NREG = 2**REG_AW;
    localparam logic [2:0] OPC_LOAD = 3'b111;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t              state;
    logic [DW-1:0]       regs [NREG];
    logic [REG_AW-1:0]   rd_q;
    logic [DW-1:0]       ld_q;

    logic [2:0]          dec_opc;
    logic [REG_AW-1:0]   dec_rd;
    logic [REG_AW-1:0]   dec_ra;
    logic [REG_AW-1:0]   dec_rb;
    logic                dec_inc;

    logic [DW-1:0]       wb_data;
    logic                wb_z;
    logic                wb_n;

    assign dec_opc  = instr[IW-1 -: 3];
    assign dec_rd   = instr[3*REG_AW -: REG_AW];
    assign dec_ra   = instr[2*REG_AW -: REG_AW];
    assign dec_rb   = instr[REG_AW -: REG_AW];
    assign dec_inc  = instr[0];

    assign in_ready = (state == IDLE);
    assign dbg_data = regs[dbg_addr];

    // The latched opcode doubles as the LOAD selector: for LOAD the ALU output
    // is ignored and flags are derived from the immediate itself.
    always_comb begin
        wb_data = alu_w;
        wb_z    = alu_zer;
        wb_n    = alu_neg;
        if (alu_opc == OPC_LOAD) begin
            wb_data = ld_q;
            wb_z    = (ld_q == '0);
            wb_n    = ld_q[DW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            rd_q    <= '0;
            ld_q    <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_opc <= 3'b000;
            alu_inc <= 1'b0;
            done    <= 1'b0;
            res     <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
`ifdef ALU_ISSUE_SEQ_ICOUNT_EN
            icount  <= 16'h0000;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Operands are read here, before any write of this
                        // instruction, so rd may alias ra/rb.
                        alu_a   <= regs[dec_ra];
                        alu_b   <= regs[dec_rb];
                        alu_opc <= dec_opc;
                        alu_inc <= dec_inc;
                        rd_q    <= dec_rd;
                        ld_q    <= ld_data;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    regs[rd_q] <= wb_data;
                    res        <= wb_data;
                    flag_z     <= wb_z;
                    flag_n     <= wb_n;
                    done       <= 1'b1;
`ifdef ALU_ISSUE_SEQ_ICOUNT_EN
                    icount     <= icount + 16'h0001;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
